imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
- Sequences program download from the SPI slave into the CPU instruction memory write port, and controls CPU reset.
- Parses a framed image (header length, data words, checksum) and generates registered memory write strobes and addresses.
- Holds the CPU in reset during download; releases it a fixed number of cycles after a verified image and chip-select release.
- Sits between the spi block and cpu_top in the top level.

Parameters:
- iaddr_width, 8, instruction memory address width; max image = 2**iaddr_width words
- width, 16, SPI word and instruction width
- hold_cycles, 4, cycles cpu_reset stays high after a good load before release (≥1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- new_transfer  input  1  one-cycle pulse from spi at chip-select assertion
- chip_selected  input  1  spi chip select active (level)
- transfer_done  input  1  one-cycle pulse from spi at chip-select release
- data_ready  input  1  one-cycle pulse: shiftreg holds a complete word
- shiftreg  input  width  received SPI word
- iaddr_write  output  iaddr_width  instruction memory write address
- idata_write  output  width  instruction memory write data
- i_write  output  1  instruction memory write enable, one cycle per word
- cpu_reset  output  1  reset to cpu_top
- load_done  output  1  high while CPU is running a verified image
- load_error  output  1  sticky error flag

Behaviour:
- Reset values: state IDLE, iaddr_write=0, idata_write=0, i_write=0, cpu_reset=1, load_done=0, load_error=0, internal len/count/sum/hold counter=0.
- States: IDLE, HEADER, DATA, CHECK, HOLD, RUN, ERROR.
- new_transfer in any state (except during reset) -> HEADER next cycle; clears sum, count, load_error, load_done; sets iaddr_write to 0; cpu_reset=1.
- If new_transfer and data_ready occur in the same cycle, new_transfer wins and the word is dropped.
- IDLE: cpu_reset=1; waits for new_transfer.
- HEADER: on data_ready, len=shiftreg.
  - If 1 ≤ len ≤ 2**iaddr_width -> DATA; otherwise -> ERROR.
  - The header is not written and not summed.
- DATA: on data_ready, the next cycle has i_write=1, idata_write=word, iaddr_write=count[iaddr_width-1:0]. Write latency is 1 cycle.
  - sum = (sum + word) mod 2**width; count increments.
  - When count reaches len -> CHECK. Address never wraps and never writes beyond len-1.
  - iaddr_write holds the last written address between writes.
- CHECK: on data_ready, word == sum -> HOLD; word != sum -> ERROR. The checksum word is never written.
- transfer_done while in HEADER, DATA or CHECK -> ERROR (truncated image).
- HOLD: cpu_reset=1.
  - Hold counter loads hold_cycles and decrements only while chip_selected=0.
  - At 0 -> RUN. cpu_reset falls on the first RUN cycle.
  - data_ready in HOLD is ignored (trailing words discarded, no write).
- RUN: cpu_reset=0, load_done=1. data_ready and transfer_done are ignored. Only new_transfer leaves RUN.
- ERROR: cpu_reset=1, load_error=1 (sticky).
  - Memory contents are undefined (partial writes may have occurred).
  - Leaves only on new_transfer or reset.
- i_write is never asserted outside the cycle after an accepted DATA word.
- Reset mid-operation returns every output to its reset value. The CPU stays in reset until a full valid load.

Test Plan:
- Good load: new_transfer, words 0x0003, 0x1111, 0x2222, 0x3333, 0x6666, then transfer_done -> i_write pulses at addr 0,1,2 with 0x1111/0x2222/0x3333; cpu_reset=1 for exactly 4 cycles after chip_selected falls, then 0; load_done=1; load_error=0.
- Bad checksum: same frame with 0x6667 -> 3 writes occur, then load_error=1, cpu_reset stays 1, load_done=0; a following good frame clears load_error and reaches RUN.
- Truncated and bad header:
  - Header 0x0003, two data words, transfer_done -> ERROR, 2 writes only.
  - Header 0x0000 or 0x0101 -> ERROR, zero i_write pulses.
- Arithmetic and boundaries:
  - Header 0x0002, words 0xFFFF, 0x0002, checksum 0x0001 -> passes (mod-2**16 sum).
  - Header 0x0100 with 256 words -> addresses 0..255 each written once, last at 0xFF, no wrap.
- Chip select held after checksum: extra words after checksum while chip_selected=1 -> no writes; hold countdown starts only after chip_selected=0.
- Reload and reset:
  - new_transfer in RUN -> cpu_reset=1 and load_done=0 next cycle; iaddr_write restarts at 0.
  - new_transfer coincident with data_ready -> word dropped.
  - reset asserted mid-DATA -> all outputs at reset values, state IDLE, no further i_write.

Source files
------------

// File: rtl/imem_boot_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl_if
//
// Purpose: bundles the signals between the boot controller and its
// surroundings. On one side are the SPI word stream and chip-select events. On
// the other side are the instruction memory write port and the CPU
// reset/status outputs.
//
// Signals (direction as seen from the boot controller, modport master):
//   new_transfer   in   1            pulse at chip-select assertion
//   chip_selected  in   1            chip select active (level)
//   transfer_done  in   1            pulse at chip-select release
//   data_ready     in   1            pulse: shiftreg holds a complete word
//   shiftreg       in   width        received SPI word
//   iaddr_write    out  iaddr_width  instruction memory write address
//   idata_write    out  width        instruction memory write data
//   i_write        out  1            instruction memory write enable
//   cpu_reset      out  1            reset to the CPU
//   load_done      out  1            CPU running a verified image
//   load_error     out  1            sticky load error
//
// The slave modport is the mirror image, for the SPI/memory/CPU side or a
// testbench.
// -----------------------------------------------------------------------------
interface imem_boot_ctrl_if #(
    parameter int iaddr_width = 8,
    parameter int width       = 16
);
    logic                   new_transfer;
    logic                   chip_selected;
    logic                   transfer_done;
    logic                   data_ready;
    logic [width-1:0]       shiftreg;
    logic [iaddr_width-1:0] iaddr_write;
    logic [width-1:0]       idata_write;
    logic                   i_write;
    logic                   cpu_reset;
    logic                   load_done;
    logic                   load_error;

    modport master (
        input  new_transfer,
        input  chip_selected,
        input  transfer_done,
        input  data_ready,
        input  shiftreg,
        output iaddr_write,
        output idata_write,
        output i_write,
        output cpu_reset,
        output load_done,
        output load_error
    );

    modport slave (
        output new_transfer,
        output chip_selected,
        output transfer_done,
        output data_ready,
        output shiftreg,
        input  iaddr_write,
        input  idata_write,
        input  i_write,
        input  cpu_reset,
        input  load_done,
        input  load_error
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Purpose: downloads a program image received over SPI into the CPU
// instruction memory, and controls the CPU reset.
//
// The image is framed as follows:
//   word 0           : length len (1 .. 2**iaddr_width), not written
//   words 1 .. len   : instruction words, written to addresses 0 .. len-1
//   word len+1       : checksum = sum of the instruction words mod 2**width
//
// The CPU is held in reset while an image is being loaded. After the checksum
// verifies and chip select is released, reset is held for another hold_cycles
// cycles and then released. Any malformed or truncated frame parks the block
// in ERROR, with the sticky load_error flag set, until the next frame arrives.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    imem_boot_ctrl_if.master, which carries the SPI event/word inputs,
//          the memory write port (iaddr_write, idata_write, i_write), and the
//          cpu_reset, load_done and load_error outputs
//
// Parameters:
//   iaddr_width  instruction memory address width
//   width        SPI word / instruction width
//   hold_cycles  cycles cpu_reset stays high after chip select release (>= 1)
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int iaddr_width = 8,
    parameter int width       = 16,
    parameter int hold_cycles = 4
) (
    input  logic            clk,
    input  logic            reset,
    imem_boot_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        HOLD,
        RUN,
        ERROR
    } state_t;

    // The word count needs one more bit than an address, so that it can hold a
    // full-memory image length of 2**iaddr_width.
    typedef logic [iaddr_width:0] cnt_t;

    // Common width used to compare the raw header word with the maximum length.
    localparam int cmp_w  = (width > iaddr_width + 1) ? width : iaddr_width + 1;
    typedef logic [cmp_w-1:0] cmp_t;
    localparam cmp_t max_len = cmp_t'(1) << iaddr_width;

    localparam int hold_w = (hold_cycles < 2) ? 1 : $clog2(hold_cycles + 1);
    typedef logic [hold_w-1:0] hold_t;

    state_t                 state_q;
    cnt_t                   len_q;
    cnt_t                   count_q;
    logic [width-1:0]       sum_q;
    hold_t                  hold_q;
    logic [iaddr_width-1:0] iaddr_write_q;
    logic [width-1:0]       idata_write_q;
    logic                   i_write_q;
    logic                   cpu_reset_q;
    logic                   load_done_q;
    logic                   load_error_q;

    logic             header_ok;
    cnt_t             count_d;
    logic [width-1:0] sum_d;
    logic             last_word;
    logic             truncated;

    assign header_ok = (bus.shiftreg != '0) && (cmp_t'(bus.shiftreg) <= max_len);
    assign count_d   = count_q + cnt_t'(1);
    // The running sum wraps naturally at 2**width.
    assign sum_d     = sum_q + bus.shiftreg;
    assign last_word = (count_d == len_q);
    // Chip select released before the checksum was seen.
    assign truncated = bus.transfer_done && (state_q inside {HEADER, DATA, CHECK});

    // NOTE: every register in this block uses non-blocking assignments. All
    // reads then see the values from before the clock edge, regardless of the
    // order of the statements below.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is only sampled on the clock edge.
        // A reset in the middle of a transfer takes effect at the next edge and
        // returns every output to its idle value.
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            sum_q         <= '0;
            hold_q        <= '0;
            iaddr_write_q <= '0;
            idata_write_q <= '0;
            i_write_q     <= 1'b0;
            cpu_reset_q   <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse. It defaults low and is
            // raised only when a DATA word is accepted.
            i_write_q <= 1'b0;

            if (bus.new_transfer) begin
                // A new frame overrides everything, including a data_ready in
                // the same cycle: that word is dropped.
                state_q       <= HEADER;
                sum_q         <= '0;
                count_q       <= '0;
                iaddr_write_q <= '0;
                cpu_reset_q   <= 1'b1;
                load_done_q   <= 1'b0;
                load_error_q  <= 1'b0;
            end else if (truncated) begin
                state_q      <= ERROR;
                load_error_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        cpu_reset_q <= 1'b1;
                    end

                    HEADER: begin
                        if (bus.data_ready) begin
                            len_q <= cnt_t'(bus.shiftreg);
                            if (header_ok) begin
                                state_q <= DATA;
                            end else begin
                                state_q      <= ERROR;
                                load_error_q <= 1'b1;
                            end
                        end
                    end

                    DATA: begin
                        if (bus.data_ready) begin
                            i_write_q     <= 1'b1;
                            idata_write_q <= bus.shiftreg;
                            iaddr_write_q <= count_q[iaddr_width-1:0];
                            sum_q         <= sum_d;
                            count_q       <= count_d;
                            // len >= 1 guarantees that count never passes len,
                            // so the address cannot wrap.
                            if (last_word) begin
                                state_q <= CHECK;
                            end
                        end
                    end

                    CHECK: begin
                        if (bus.data_ready) begin
                            if (bus.shiftreg == sum_q) begin
                                state_q <= HOLD;
                                hold_q  <= hold_t'(hold_cycles);
                            end else begin
                                state_q      <= ERROR;
                                load_error_q <= 1'b1;
                            end
                        end
                    end

                    HOLD: begin
                        // Count down only after chip select has been released.
                        // Trailing words that arrive while chip select is still
                        // active are ignored.
                        if (!bus.chip_selected) begin
                            if (hold_q == hold_t'(1)) begin
                                state_q     <= RUN;
                                hold_q      <= '0;
                                cpu_reset_q <= 1'b0;
                                load_done_q <= 1'b1;
                            end else begin
                                hold_q <= hold_q - hold_t'(1);
                            end
                        end
                    end

                    // RUN and ERROR are left only through new_transfer or reset.
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.iaddr_write = iaddr_write_q;
    assign bus.idata_write = idata_write_q;
    assign bus.i_write     = i_write_q;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_error  = load_error_q;

endmodule
